// File: rtl/cr_xp10_decomp_lfa_window_fifo.sv
// Sliding-window FIFO for the LFA decompressor: writes append at the tail, reads
// are random-access anywhere inside the live window [head, tail), and the head
// is advanced explicitly by an ack carrying the new head index.
module cr_xp10_decomp_lfa_window_fifo #(
    parameter int unsigned WIDTH       = 70,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned FREE_THRESH = 16,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    output logic [AW-1:0]    waddr,
    input  logic             rd,
    input  logic [AW-1:0]    raddr,
    output logic             rd_avail,
    output logic [WIDTH-1:0] rdata,
    output logic             rdata_vld,
    input  logic             rd_ack,
    input  logic [AW-1:0]    rd_ack_addr,
    output logic             empty,
    output logic             full,
    output logic             avail,
    output logic [AW:0]      level,
    output logic             wr_ovf,
    output logic             rd_err,
    output logic             ack_err
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [AW:0]      head;
    logic [AW:0]      tail;
    logic [AW:0]      free_cnt;
    logic [AW-1:0]    head_idx;
    logic [AW-1:0]    tail_idx;
    logic             head_pg;
    logic             tail_pg;
    logic [AW-1:0]    ack_dist;
    logic             ack_legal;
    logic             wr_fire;
    logic             rd_fire;
    logic             ack_fire;
    logic [WIDTH-1:0] mem [DEPTH];

    assign head_idx = head[AW-1:0];
    assign tail_idx = tail[AW-1:0];
    assign head_pg  = head[AW];
    assign tail_pg  = tail[AW];

    assign level    = tail - head;
    assign free_cnt = DEPTH_W - level;
    assign empty    = (level == '0);
    assign full     = (level == DEPTH_W);
    assign avail    = (32'(free_cnt) > FREE_THRESH);
    assign waddr    = tail_idx;

    assign rd_avail = (head_pg == tail_pg)
                    ? ((raddr >= head_idx) && (raddr < tail_idx))
                    : ((raddr >= head_idx) || (raddr < tail_idx));

    // Adding the modular distance to the full head pointer toggles the page
    // exactly when the new index is below the old one.
    assign ack_dist  = rd_ack_addr - head_idx;
    assign ack_legal = ({1'b0, ack_dist} <= level);

    assign wr_fire  = wr & ~full & ~flush;
    assign rd_fire  = rd & rd_avail & ~flush;
    assign ack_fire = rd_ack & ack_legal & ~flush;

    // Head/tail pointer update; flush wins over write and ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (wr_fire)
                tail <= tail + (AW+1)'(1);
            if (ack_fire)
                head <= head + {1'b0, ack_dist};
        end
    end

    // One-cycle status pulses and read-data valid, all masked by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_vld <= 1'b0;
            wr_ovf    <= 1'b0;
            rd_err    <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            rdata_vld <= rd_fire;
            wr_ovf    <= wr & full & ~flush;
            rd_err    <= rd & ~rd_avail & ~flush;
            ack_err   <= rd_ack & ~ack_legal & ~flush;
        end
    end

    // Registered read port; data holds whenever no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (rd_fire)
            rdata <= mem[raddr];
    end

    // Storage write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[tail_idx] <= wdata;
    end

endmodule
